muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequencer between the execute stage and the shared iterative multiplier/divider.
- Accepts one mul/div/rem op, launches the correct unit, and stalls the pipeline until the result is ready.
- Resolves the RISC-V divide special cases (divide by zero, signed overflow) without using the unit.
- Delivers a one-cycle done pulse with the final 64-bit result, which the execute stage selects as alu_result.

Parameters:
XLEN, 64, datapath width
MUL_LAT, 3, fixed multiplier latency in cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_i  in  1  execute stage holds a mul/div op; held stable while stall_o=1
op_i  in  3  mdop_t: MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU
word_i  in  1  W-variant: operate on low 32 bits, sign-extend the result
a_i  in  XLEN  rs1 value
b_i  in  XLEN  rs2 value
flush_i  in  1  pipeline flush; abort the op in flight
stall_o  out  1  freeze fetch/decode/execute
done_o  out  1  result valid this cycle; pipeline advances
result_o  out  XLEN  final result
start_mul_o  out  1  one-cycle multiplier launch
start_div_o  out  1  one-cycle divider launch
abort_o  out  1  one-cycle cancel to the unit
opa_o  out  XLEN  prepared operand A
opb_o  out  XLEN  prepared operand B
signed_o  out  1  signed division
prod_i  in  XLEN  multiplier low product, valid MUL_LAT cycles after start
quot_i  in  XLEN  divider quotient
rem_i  in  XLEN  divider remainder
div_done_i  in  1  divider result valid (single-cycle pulse)

Behaviour:
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE. Reset to IDLE; every output is 0 at reset, including result_o.
- stall_o is combinational: (valid_i & state==IDLE) | state==MUL_BUSY | state==DIV_BUSY. It is 0 in DONE.
- Operand prep (combinational, drives opa_o/opb_o):
  - word_i=1: low 32 bits are sign-extended for MD_MUL/DIV/REM and zero-extended for DIVU/REMU.
  - word_i=0: operands pass through.
- signed_o = op is DIV or REM.
- IDLE with valid_i, not flushed:
  - Div-type op with opb==0: latch quotient = all-ones, remainder = opa. No unit start. Go to DONE.
  - Signed div with opa == most-negative value (of the 32- or 64-bit width) and opb == -1: latch quotient = opa, remainder = 0. No unit start. Go to DONE.
  - MD_MUL: pulse start_mul_o, load counter = MUL_LAT, go to MUL_BUSY.
  - Otherwise: pulse start_div_o, go to DIV_BUSY.
- MUL_BUSY: counter decrements each cycle. When the counter reaches 1, capture prod_i and go to DONE. The accept cycle is cycle 0 and done_o is asserted in cycle MUL_LAT+1.
- DIV_BUSY: wait with no timeout. On div_done_i, capture quot_i (DIV/DIVU) or rem_i (REM/REMU) and go to DONE.
- Result formatting at capture: word_i=1 gives the low 32 bits sign-extended to 64.
- DONE: done_o=1 and result_o holds the captured value, for exactly one cycle; then go to IDLE.
  - result_o keeps its value until the next capture.
  - A new valid op is accepted only from IDLE, so back-to-back ops have one IDLE accept cycle between them.
- flush_i has priority over all other transitions:
  - The state goes to IDLE; no start_* pulse is issued that cycle.
  - If the state was MUL_BUSY or DIV_BUSY, abort_o pulses.
  - flush_i in DONE suppresses done_o.
  - div_done_i arriving in the same cycle as flush_i is ignored.
- div_done_i or prod_i outside the matching busy state is ignored.
- Reset mid-operation: everything returns to the reset values and no abort_o is issued; reset also resets the unit.

Decomposition:
- Package pipes gets:
  - mdop_t enum
  - md_state_t enum
  - helper constants MIN64, MIN32_SEXT
  - md_req_t struct {op, word, a, b}
- One combinational sub-module is natural: muldiv_prep (operand extension plus special-case detection and fixed result). The FSM, counter and capture logic stay in muldiv_ctrl.

Test Plan:
- MUL, a=7, b=6, MUL_LAT=3 -> start_mul_o in cycle 0; stall_o=1 in cycles 0-3; done_o=1 in cycle 4 with result_o=42; stall_o=0 in cycle 4.
- DIV, a=5, b=0 -> no start_div_o; done_o in cycle 1 with result_o=0xFFFF_FFFF_FFFF_FFFF. Same inputs with REMU -> result_o=5.
- DIV, a=0x8000_0000_0000_0000, b=-1 -> result_o=0x8000_0000_0000_0000 in cycle 1. REM with the same inputs -> result_o=0.
- DIV, word_i=1, a=0x0000_0000_FFFF_FFF9, b=2, model drives div_done_i in cycle 10 with quot_i=-3 -> opa_o=0xFFFF_FFFF_FFFF_FFF9, signed_o=1, done_o in cycle 11, result_o=0xFFFF_FFFF_FFFF_FFFD.
- DIVU in flight, flush_i in cycle 5, div_done_i in cycle 5 -> abort_o pulse in cycle 5; state returns to IDLE; done_o never asserts; stall_o=0 in cycle 6.
- MUL in flight, reset in cycle 2 -> all outputs 0 in cycle 3. A following MUL 3*3 -> done_o with result_o=9 after MUL_LAT+1 cycles.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the mul/div sequencer.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MUL  = 3'd0,
        MD_DIV  = 3'd1,
        MD_DIVU = 3'd2,
        MD_REM  = 3'd3,
        MD_REMU = 3'd4
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } md_state_t;

    localparam logic [63:0] MIN64      = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MIN32_SEXT = 64'hFFFF_FFFF_8000_0000;

    typedef struct packed {
        mdop_t       op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
    } md_req_t;

endpackage

// File: rtl/muldiv_ctrl_prep.sv
// Operand extension plus detection of the divide cases that never reach the unit.
module muldiv_ctrl_prep
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] opa_o,
    output logic [XLEN-1:0] opb_o,
    output logic            signed_o,
    output logic            special_o,
    output logic [XLEN-1:0] special_res_o
);

    function automatic logic signed [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    mdop_t                  op;
    logic                   is_div;
    logic                   is_rem;
    logic                   is_signed;
    logic signed [XLEN-1:0] opa_s;
    logic signed [XLEN-1:0] opb_s;
    logic                   div_zero;
    logic                   div_ovf;
    logic [XLEN-1:0]        raw_res;

    assign op        = mdop_t'(op_i);
    assign is_div    = (op != MD_MUL);
    assign is_rem    = (op == MD_REM) || (op == MD_REMU);
    assign is_signed = (op == MD_DIV) || (op == MD_REM);

    // Extend W-variant operands by signedness; unsigned divides zero-extend.
    always_comb begin
        opa_s = a_i;
        opb_s = b_i;
        if (word_i) begin
            if (op == MD_DIVU || op == MD_REMU) begin
                opa_s = zext32(a_i);
                opb_s = zext32(b_i);
            end else begin
                opa_s = sext32(a_i);
                opb_s = sext32(b_i);
            end
        end
    end

    // Sign-extended -1 is all-ones at either width, so one compare covers both.
    assign div_zero = is_div && (opb_s == '0);
    assign div_ovf  = is_signed && (opb_s == '1) &&
                      (word_i ? (opa_s == MIN32_SEXT) : (opa_s == MIN64));

    // Fixed architectural results, formatted the same way a unit result would be.
    always_comb begin
        raw_res = '0;
        if (div_zero)
            raw_res = is_rem ? opa_s : '1;
        else if (div_ovf)
            raw_res = is_rem ? '0 : opa_s;
        special_res_o = word_i ? sext32(raw_res) : raw_res;
    end

    assign opa_o     = opa_s;
    assign opb_o     = opb_s;
    assign signed_o  = is_signed;
    assign special_o = div_zero || div_ovf;

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer that launches the shared mul/div unit, stalls the pipe and returns the result.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            start_mul_o,
    output logic            start_div_o,
    output logic            abort_o,
    output logic [XLEN-1:0] opa_o,
    output logic [XLEN-1:0] opb_o,
    output logic            signed_o,
    input  logic [XLEN-1:0] prod_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] rem_i,
    input  logic            div_done_i
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    function automatic logic [XLEN-1:0] fmt_res(input logic [XLEN-1:0] v, input logic word);
        return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    md_req_t         req;
    md_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt_p0;
    mdop_t           op_p0;
    logic            word_p0;
    logic [XLEN-1:0] result_p0;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            accept;
    logic            cnt_last;
    logic            cap_spec, cap_mul, cap_div;

    assign req = '{op: mdop_t'(op_i), word: word_i, a: a_i, b: b_i};

    muldiv_ctrl_prep #(.XLEN(XLEN)) u_prep (
        .op_i          (req.op),
        .word_i        (req.word),
        .a_i           (req.a),
        .b_i           (req.b),
        .opa_o         (opa_o),
        .opb_o         (opb_o),
        .signed_o      (signed_o),
        .special_o     (special),
        .special_res_o (special_res)
    );

    assign accept   = (state == IDLE) && valid_i && !flush_i;
    assign cnt_last = (cnt_p0 == CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (valid_i) state_nxt = special ? DONE :
                                                   (req.op == MD_MUL) ? MUL_BUSY : DIV_BUSY;
                MUL_BUSY: if (cnt_last) state_nxt = DONE;
                DIV_BUSY: if (div_done_i) state_nxt = DONE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Control outputs and capture strobes; all held low while in reset.
    always_comb begin
        stall_o     = 1'b0;
        done_o      = 1'b0;
        start_mul_o = 1'b0;
        start_div_o = 1'b0;
        abort_o     = 1'b0;
        cap_spec    = 1'b0;
        cap_mul     = 1'b0;
        cap_div     = 1'b0;
        if (!reset) begin
            stall_o     = (valid_i && state == IDLE) || state == MUL_BUSY || state == DIV_BUSY;
            done_o      = (state == DONE) && !flush_i;
            start_mul_o = accept && !special && (req.op == MD_MUL);
            start_div_o = accept && !special && (req.op != MD_MUL);
            abort_o     = flush_i && (state == MUL_BUSY || state == DIV_BUSY);
            cap_spec    = accept && special;
            cap_mul     = (state == MUL_BUSY) && cnt_last && !flush_i;
            cap_div     = (state == DIV_BUSY) && div_done_i && !flush_i;
        end
    end

    // Latency counter and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0    <= '0;
            result_p0 <= '0;
        end else begin
            if (start_mul_o)
                cnt_p0 <= CNT_W'(MUL_LAT);
            else if (state == MUL_BUSY)
                cnt_p0 <= cnt_p0 - CNT_W'(1);
            if (cap_spec)
                result_p0 <= special_res;
            else if (cap_mul)
                result_p0 <= fmt_res(prod_i, word_p0);
            else if (cap_div)
                result_p0 <= fmt_res((op_p0 == MD_REM || op_p0 == MD_REMU) ? rem_i : quot_i,
                                     word_p0);
        end
    end

    // Accepted op attributes used when the unit result comes back.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0   <= req.op;
            word_p0 <= req.word;
        end
    end

    assign result_o = result_p0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; the bench plays the role of the mul/div unit.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int XLEN    = 64;
    localparam int MUL_LAT = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_i;
    logic [2:0]      op_i;
    logic            word_i;
    logic [XLEN-1:0] a_i, b_i;
    logic            flush_i;
    logic            stall_o, done_o, start_mul_o, start_div_o, abort_o, signed_o;
    logic [XLEN-1:0] result_o, opa_o, opb_o;
    logic [XLEN-1:0] prod_i, quot_i, rem_i;
    logic            div_done_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (valid_i),
        .op_i        (op_i),
        .word_i      (word_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .start_mul_o (start_mul_o),
        .start_div_o (start_div_o),
        .abort_o     (abort_o),
        .opa_o       (opa_o),
        .opb_o       (opb_o),
        .signed_o    (signed_o),
        .prod_i      (prod_i),
        .quot_i      (quot_i),
        .rem_i       (rem_i),
        .div_done_i  (div_done_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point for the current cycle, away from the active edge.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic quiet();
        valid_i    = 1'b0;
        op_i       = 3'd0;
        word_i     = 1'b0;
        a_i        = '0;
        b_i        = '0;
        flush_i    = 1'b0;
        prod_i     = '0;
        quot_i     = '0;
        rem_i      = '0;
        div_done_i = 1'b0;
    endtask

    task automatic issue(input mdop_t op, input logic word, input logic [63:0] a,
                         input logic [63:0] b);
        valid_i = 1'b1;
        op_i    = op;
        word_i  = word;
        a_i     = a;
        b_i     = b;
    endtask

    // A divide that resolves without the unit: done in cycle 1 with the fixed result.
    task automatic special_div(input string tag, input mdop_t op, input logic word,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] exp);
        issue(op, word, a, b);
        sample();
        chk({tag, "_nostart"}, {62'd0, start_div_o, start_mul_o}, 64'd0);
        chk({tag, "_stall0"}, stall_o, 1);
        tick();
        quiet();
        sample();
        chk({tag, "_done"}, done_o, 1);
        chk({tag, "_res"}, result_o, exp);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        reset = 1'b1;
        tick();
        tick();
        sample();
        chk("rst_stall", stall_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_starts", {61'd0, abort_o, start_div_o, start_mul_o}, 0);
        tick();
        reset = 1'b0;
        tick();

        // MUL 7*6: stall in cycles 0..3, done in cycle 4
        issue(MD_MUL, 1'b0, 64'd7, 64'd6);
        sample();
        chk("mul_start", start_mul_o, 1);
        chk("mul_stall_c0", stall_o, 1);
        chk("mul_opa", opa_o, 64'd7);
        for (int c = 1; c <= MUL_LAT; c++) begin
            tick();
            if (c == MUL_LAT) prod_i = 64'd42;
            sample();
            chk("mul_stall_busy", stall_o, 1);
            chk("mul_nodone_busy", done_o, 0);
            chk("mul_start_once", start_mul_o, 0);
        end
        tick();
        quiet();
        sample();
        chk("mul_done", done_o, 1);
        chk("mul_res", result_o, 64'd42);
        chk("mul_stall_done", stall_o, 0);
        tick();
        sample();
        chk("mul_done_1cyc", done_o, 0);
        chk("mul_res_hold", result_o, 64'd42);
        tick();

        // Divide-by-zero and signed overflow resolved locally
        special_div("divz", MD_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        special_div("remuz", MD_REMU, 1'b0, 64'd5, 64'd0, 64'd5);
        special_div("ovf_div", MD_DIV, 1'b0, 64'h8000_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        special_div("ovf_rem", MD_REM, 1'b0, 64'h8000_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        // REMUW by zero: remainder is the zero-extended low word, then sign-extended
        special_div("remuwz", MD_REMU, 1'b1, 64'h0000_0001_8000_0000, 64'd0,
                    64'hFFFF_FFFF_8000_0000);
        // DIVW overflow on the 32-bit boundary
        special_div("ovf_divw", MD_DIV, 1'b1, 64'h0000_0000_8000_0000,
                    64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);

        // Flush during DONE suppresses done_o
        issue(MD_DIV, 1'b0, 64'd9, 64'd0);
        tick();
        quiet();
        flush_i = 1'b1;
        sample();
        chk("flush_done_sup", done_o, 0);
        chk("flush_done_noabort", abort_o, 0);
        tick();
        quiet();

        // DIVW through the unit, result in cycle 10
        issue(MD_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);
        sample();
        chk("divw_opa", opa_o, 64'hFFFF_FFFF_FFFF_FFF9);
        chk("divw_opb", opb_o, 64'd2);
        chk("divw_signed", signed_o, 1);
        chk("divw_start", start_div_o, 1);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 10) begin
                div_done_i = 1'b1;
                quot_i     = 64'hFFFF_FFFF_FFFF_FFFD;
                rem_i      = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            sample();
            chk("divw_stall", stall_o, 1);
            chk("divw_nodone", done_o, 0);
        end
        tick();
        quiet();
        sample();
        chk("divw_done", done_o, 1);
        chk("divw_res", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
        tick();

        // DIVU aborted by flush in cycle 5 while the unit reports done
        issue(MD_DIVU, 1'b0, 64'd100, 64'd7);
        sample();
        chk("divu_start", start_div_o, 1);
        chk("divu_unsigned", signed_o, 0);
        for (int c = 1; c <= 4; c++) tick();
        tick();
        flush_i    = 1'b1;
        div_done_i = 1'b1;
        quot_i     = 64'd14;
        sample();
        chk("flush_abort", abort_o, 1);
        chk("flush_nodone", done_o, 0);
        tick();
        quiet();
        sample();
        chk("flush_stall_c6", stall_o, 0);
        chk("flush_abort_1cyc", abort_o, 0);
        chk("flush_nodone_c6", done_o, 0);
        tick();
        sample();
        chk("flush_nodone_c7", done_o, 0);
        chk("flush_res_kept", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
        tick();

        // MUL interrupted by reset in cycle 2
        issue(MD_MUL, 1'b0, 64'd3, 64'd5);
        tick();
        tick();
        reset = 1'b1;
        sample();
        chk("rstmid_noabort", abort_o, 0);
        tick();
        reset = 1'b0;
        quiet();
        sample();
        chk("rstmid_stall", stall_o, 0);
        chk("rstmid_done", done_o, 0);
        chk("rstmid_result", result_o, 0);
        chk("rstmid_ctrl", {61'd0, abort_o, start_div_o, start_mul_o}, 0);
        tick();

        // Fresh MUL 3*3 after reset
        issue(MD_MUL, 1'b0, 64'd3, 64'd3);
        sample();
        chk("mul2_start", start_mul_o, 1);
        for (int c = 1; c <= MUL_LAT; c++) begin
            tick();
            if (c == MUL_LAT) prod_i = 64'd9;
            sample();
            chk("mul2_nodone", done_o, 0);
        end
        tick();
        quiet();
        sample();
        chk("mul2_done", done_o, 1);
        chk("mul2_res", result_o, 64'd9);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
